// File: rtl/display_scan_if.sv
// Bus between the grade datapath and the display scan controller.
// The datapath side drives the enable, load and value signals. The controller
// side drives the shared decoder code, the digit enables and the frame pulse.
interface display_scan_if #(
  parameter int NUM_DIG = 4
);
  logic                   enable;
  logic                   load;
  logic [4*NUM_DIG-1:0]   valores;
  logic [3:0]             nota_out;
  logic [NUM_DIG-1:0]     an_n;
  logic                   frame_end;

  modport master (
    output enable, load, valores,
    input  nota_out, an_n, frame_end
  );

  modport slave (
    input  enable, load, valores,
    output nota_out, an_n, frame_end
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// NUM_DIG 4-bit codes share one decoder. Each digit slot is DIV cycles long.
// The first GAP cycles of a slot keep every anode off so the previous digit
// does not ghost into the next one.
// Values are double-buffered: new data is swapped in only at a frame boundary,
// so a single frame never mixes old and new data.
module display_scan_ctrl #(
  parameter int NUM_DIG     = 4,
  parameter int DIV         = 50000,
  parameter int GAP         = 2,
  parameter int BLANK_ZEROS = 1
) (
  input  logic          clk,
  input  logic          rst,
  display_scan_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int VW = 4 * NUM_DIG;

  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);
  localparam logic [3:0]    BLANK    = 4'hF;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_GAP = 2'd1,
    S_ON  = 2'd2
  } state_t;

  // Leading-zero mask: digit i>0 is dark when it and every higher digit are 0.
  function automatic logic [NUM_DIG-1:0] blank_mask(input logic [VW-1:0] vals);
    logic               run;
    logic [NUM_DIG-1:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      run  = run & (vals[4*i +: 4] == 4'h0);
      m[i] = run & (i != 0) & (BLANK_ZEROS != 0);
    end
    return m;
  endfunction

  state_t             state;
  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [VW-1:0]      active;
  logic [VW-1:0]      pending;
  logic               pend_flag;
  logic [3:0]         nota_r;
  logic [NUM_DIG-1:0] an_n_r;
  logic               frame_end_r;

  state_t             state_n;
  logic [PW-1:0]      presc_n;
  logic [IW-1:0]      idx_n;
  logic [VW-1:0]      active_n;
  logic [VW-1:0]      pending_n;
  logic               pend_flag_n;
  logic               tick;
  logic               boundary;
  logic [NUM_DIG-1:0] mask_n;
  logic [3:0]         nota_n;
  logic [NUM_DIG-1:0] an_n_n;

  // Next scan position, buffer swap and output codes. The outputs are
  // computed from the next state so the registered outputs line up with the
  // state register on every cycle.
  always_comb begin
    tick        = (state == S_ON) && (presc == DIV_LAST);
    boundary    = bus.enable && tick && (idx == IDX_LAST);
    state_n     = state;
    presc_n     = presc;
    idx_n       = idx;
    active_n    = active;
    pending_n   = pending;
    pend_flag_n = pend_flag;

    if (!bus.enable) begin
      state_n = S_OFF;
      presc_n = '0;
      idx_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = (GAP == 0) ? S_ON : S_GAP;
          presc_n = '0;
          idx_n   = '0;
        end
        S_GAP: begin
          presc_n = presc + PW'(1);
          if (presc == GAP_LAST) state_n = S_ON;
        end
        S_ON: begin
          if (tick) begin
            presc_n = '0;
            idx_n   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            state_n = (GAP == 0) ? S_ON : S_GAP;
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        default: begin
          state_n = S_OFF;
          presc_n = '0;
          idx_n   = '0;
        end
      endcase
    end

    // While dark, or when a load lands on the frame boundary, the new
    // values bypass the pending buffer. Otherwise the last load before the
    // boundary waits in pending.
    if (bus.load) pending_n = bus.valores;
    if (bus.load && ((state == S_OFF) || boundary)) begin
      active_n    = bus.valores;
      pend_flag_n = 1'b0;
    end else if (bus.load) begin
      pend_flag_n = 1'b1;
    end else if (boundary && pend_flag) begin
      active_n    = pending;
      pend_flag_n = 1'b0;
    end

    mask_n = blank_mask(active_n);
    if (state_n == S_ON) begin
      an_n_n = ~({{(NUM_DIG-1){1'b0}}, 1'b1} << idx_n);
      nota_n = mask_n[idx_n] ? BLANK : active_n[{idx_n, 2'b00} +: 4];
    end else begin
      an_n_n = '1;
      nota_n = BLANK;
    end
  end

  // Scan FSM with registered outputs. Reset darkens the display at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_OFF;
      presc       <= '0;
      idx         <= '0;
      active      <= '0;
      pending     <= '0;
      pend_flag   <= 1'b0;
      nota_r      <= BLANK;
      an_n_r      <= '1;
      frame_end_r <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      idx         <= idx_n;
      active      <= active_n;
      pending     <= pending_n;
      pend_flag   <= pend_flag_n;
      nota_r      <= nota_n;
      an_n_r      <= an_n_n;
      frame_end_r <= boundary;
    end
  end

  assign bus.nota_out  = nota_r;
  assign bus.an_n      = an_n_r;
  assign bus.frame_end = frame_end_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=4, GAP=1, NUM_DIG=4.
// Two instances share the same stimulus: one blanks leading zeros and the
// other does not.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] valores;
  int          passed;
  int          total;

  display_scan_if #(.NUM_DIG(4)) bus ();
  display_scan_if #(.NUM_DIG(4)) bus_nb ();

  assign bus.enable     = enable;
  assign bus.load       = load;
  assign bus.valores    = valores;
  assign bus_nb.enable  = enable;
  assign bus_nb.load    = load;
  assign bus_nb.valores = valores;

  display_scan_ctrl #(.NUM_DIG(4), .DIV(4), .GAP(1), .BLANK_ZEROS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  display_scan_ctrl #(.NUM_DIG(4), .DIV(4), .GAP(1), .BLANK_ZEROS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Walks one whole frame starting at the gap cycle of digit 0. exp/exp_nb
  // hold the expected code per digit (nibble i = digit i). Up to two loads
  // are placed at frame cycles lc1/lc2 (-1 = none).
  task automatic check_frame(input logic [15:0] exp, input logic [15:0] exp_nb,
                             input int lc1, input logic [15:0] v1,
                             input int lc2, input logic [15:0] v2,
                             input string tag);
    int c;
    logic [3:0] an_e;
    logic [3:0] nt_e;
    logic [3:0] nb_e;
    c = 0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        an_e = (k == 0) ? 4'hF : ~(4'b0001 << d);
        nt_e = (k == 0) ? 4'hF : exp[4*d +: 4];
        nb_e = (k == 0) ? 4'hF : exp_nb[4*d +: 4];
        chk($sformatf("%s an_n c%0d", tag, c), {12'h0, bus.an_n}, {12'h0, an_e});
        chk($sformatf("%s nota c%0d", tag, c), {12'h0, bus.nota_out}, {12'h0, nt_e});
        chk($sformatf("%s nota_nb c%0d", tag, c), {12'h0, bus_nb.nota_out}, {12'h0, nb_e});
        if (k == 0 && d > 0)
          chk($sformatf("%s frame_end c%0d", tag, c), {15'h0, bus.frame_end}, 16'h0);
        load = (c == lc1) || (c == lc2);
        if (c == lc1) valores = v1;
        if (c == lc2) valores = v2;
        step();
        load = 1'b0;
        c++;
      end
    end
    chk($sformatf("%s frame_end end", tag), {15'h0, bus.frame_end}, 16'h1);
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    load    = 1'b0;
    valores = 16'h0;
    #1;
    chk("reset an_n", {12'h0, bus.an_n}, 16'h000F);
    chk("reset nota", {12'h0, bus.nota_out}, 16'h000F);
    chk("reset frame_end", {15'h0, bus.frame_end}, 16'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("off an_n", {12'h0, bus.an_n}, 16'h000F);

    // Enable and load 0A93 while dark: it becomes active at once.
    enable  = 1'b1;
    load    = 1'b1;
    valores = 16'h0A93;
    step();
    load = 1'b0;
    check_frame(16'hFA93, 16'h0A93, -1, 16'h0, -1, 16'h0, "t1f1");
    check_frame(16'hFA93, 16'h0A93, -1, 16'h0, -1, 16'h0, "t1f2");

    // All-zero values: only digit 0 stays lit when blanking.
    check_frame(16'hFA93, 16'h0A93, 0, 16'h0000, -1, 16'h0, "t2f1");
    check_frame(16'hFFF0, 16'h0000, -1, 16'h0, -1, 16'h0, "t2f2");

    // Two loads mid-frame: the current frame is untouched and the last one wins.
    check_frame(16'hFFF0, 16'h0000, 5, 16'h1111, 7, 16'h2222, "t3f1");
    check_frame(16'h2222, 16'h2222, -1, 16'h0, -1, 16'h0, "t3f2");

    // Load on the boundary tick; codes B and A pass through unchanged.
    check_frame(16'h2222, 16'h2222, 15, 16'h0BA7, -1, 16'h0, "t4f1");
    check_frame(16'hFBA7, 16'h0BA7, 3, 16'h1005, -1, 16'h0, "t4f2");
    check_frame(16'h1005, 16'h1005, -1, 16'h0, -1, 16'h0, "t4f3");

    // Drop enable during digit 2 ON.
    for (int i = 0; i < 10; i++) step();
    chk("t5 d2 an_n", {12'h0, bus.an_n}, 16'h000B);
    chk("t5 d2 nota", {12'h0, bus.nota_out}, 16'h0000);
    enable = 1'b0;
    step();
    chk("t5 off an_n", {12'h0, bus.an_n}, 16'h000F);
    chk("t5 off nota", {12'h0, bus.nota_out}, 16'h000F);
    load    = 1'b1;
    valores = 16'h0003;
    step();
    load = 1'b0;
    chk("t5 off load an_n", {12'h0, bus.an_n}, 16'h000F);
    chk("t5 off frame_end", {15'h0, bus.frame_end}, 16'h0);
    enable = 1'b1;
    step();
    check_frame(16'hFFF3, 16'h0003, -1, 16'h0, -1, 16'h0, "t5f1");

    // Asynchronous reset in the middle of digit 0 ON.
    step();
    step();
    chk("t6 pre an_n", {12'h0, bus.an_n}, 16'h000E);
    chk("t6 pre nota", {12'h0, bus.nota_out}, 16'h0003);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 rst an_n", {12'h0, bus.an_n}, 16'h000F);
    chk("t6 rst nota", {12'h0, bus.nota_out}, 16'h000F);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    check_frame(16'hFFF0, 16'h0000, -1, 16'h0, -1, 16'h0, "t6f1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
